flood_alarm_ctrl: RTL and testbench



---
 rtl/flood_pkg.sv | 29 ++
 rtl/flood_alarm_ctrl_if.sv | 29 ++
 rtl/seg7_scan.sv | 38 +++
 rtl/flood_alarm_ctrl.sv | 163 ++++++++++++++++
 tb/tb_flood_alarm_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/flood_pkg.sv
// flood_pkg: shared definitions for the flood alarm stage.
//   - alarm state encoding (SAFE/WARN/ALARM)
//   - default WARN/ALARM thresholds in metres
//   - seven-segment lookup for decimal digits, {dp,g,f,e,d,c,b,a}, active-high
package flood_pkg;

    typedef enum logic [1:0] {
        ST_SAFE  = 2'b00,
        ST_WARN  = 2'b01,
        ST_ALARM = 2'b10
    } alarm_state_t;

    localparam int WARN_LEVEL_DEF  = 9;
    localparam int ALARM_LEVEL_DEF = 12;

    localparam logic [7:0] SEG_LUT [0:9] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
        8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
    };

    // Non-decimal codes give a dark digit rather than garbage.
    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        if (d <= 4'd9) begin
            return SEG_LUT[d];
        end
        return 8'h00;
    endfunction

endpackage

// File: rtl/flood_alarm_ctrl_if.sv
// flood_alarm_ctrl_if: level input, alarm outputs and display outputs of the
// flood alarm stage.
//   water_level  4b  level in metres
//   alarm_state  2b  00 SAFE, 01 WARN, 10 ALARM
//   buzzer       1b  active-high buzzer drive
//   seg          8b  {dp,g,f,e,d,c,b,a}, active-high
//   seg_sel      8b  digit enables, active-low
//   btn_mute     1b  only when FLOOD_ALARM_MUTE_EN is defined
// master = the side that supplies the level, slave = flood_alarm_ctrl.
interface flood_alarm_ctrl_if;
    logic [3:0] water_level;
    logic [1:0] alarm_state;
    logic       buzzer;
    logic [7:0] seg;
    logic [7:0] seg_sel;
`ifdef FLOOD_ALARM_MUTE_EN
    logic       btn_mute;

    modport master (output water_level, btn_mute,
                    input  alarm_state, buzzer, seg, seg_sel);
    modport slave  (input  water_level, btn_mute,
                    output alarm_state, buzzer, seg, seg_sel);
`else
    modport master (output water_level,
                    input  alarm_state, buzzer, seg, seg_sel);
    modport slave  (input  water_level,
                    output alarm_state, buzzer, seg, seg_sel);
`endif
endinterface

// File: rtl/seg7_scan.sv
// seg7_scan: two-digit multiplexed seven-segment driver.
//   clk, rst          clock, async active-high reset
//   ones, tens        BCD digits
//   blank_tens        dark tens digit (its enable is still scanned)
//   seg, seg_sel      registered segment pattern / active-low digit enables
// scan = 0 shows the ones digit (seg_sel bit0 low), scan = 1 the tens digit.
module seg7_scan
    import flood_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic       blank_tens,
    output logic [7:0] seg,
    output logic [7:0] seg_sel
);

    logic scan_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_q  <= 1'b0;
            seg     <= 8'h00;
            seg_sel <= 8'hFF;
        end else begin
            scan_q <= ~scan_q;
            if (scan_q) begin
                seg     <= blank_tens ? 8'h00 : seg_decode(tens);
                seg_sel <= 8'hFD;
            end else begin
                seg     <= seg_decode(ones);
                seg_sel <= 8'hFE;
            end
        end
    end

endmodule

// File: rtl/flood_alarm_ctrl.sv
// flood_alarm_ctrl: classifies the water level into SAFE/WARN/ALARM with
// dwell-time escalation and hysteresis, drives the buzzer and shows the level
// on a two-digit multiplexed display.
//   clk, rst   clock, async active-high reset
//   bus        flood_alarm_ctrl_if.slave (water_level in; alarm_state,
//              buzzer, seg, seg_sel out; btn_mute in with the mute option)
// Optional: FLOOD_ALARM_MUTE_EN adds btn_mute; a rising edge mutes the buzzer
// until the alarm state next changes.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_SAFE  | level below thresholds, buzzer off
// ST_WARN  | level >= WARN_LEVEL for the dwell, 1 Hz beeping
// ST_ALARM | level >= ALARM_LEVEL for the dwell, continuous tone
module flood_alarm_ctrl
    import flood_pkg::*;
#(
    parameter int CLK_HZ      = 1000,
    parameter int WARN_LEVEL  = WARN_LEVEL_DEF,
    parameter int ALARM_LEVEL = ALARM_LEVEL_DEF,
    parameter int DWELL_TICKS = 2
) (
    input logic               clk,
    input logic               rst,
    flood_alarm_ctrl_if.slave bus
);

    localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;

    logic [3:0]    lvl_q;
    int            lvl_i;
    logic [CW-1:0] tick_cnt_q;
    logic          tick;
    logic          tone_q;
    alarm_state_t  state_q, state_d, req;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          buzz_raw, buzz_en, buzzer_q;
    logic [3:0]    ones, tens;
    logic          blank_tens;

    assign lvl_i = int'(lvl_q);
    assign tick  = (tick_cnt_q == CW'(CLK_HZ - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_q      <= '0;
            tick_cnt_q <= '0;
            tone_q     <= 1'b0;
        end else begin
            lvl_q      <= bus.water_level;
            tick_cnt_q <= tick ? '0 : tick_cnt_q + CW'(1);
            tone_q     <= ~tone_q;
        end
    end

    always_comb begin
        req = ST_SAFE;
        if (lvl_i >= ALARM_LEVEL) begin
            req = ST_ALARM;
        end else if (lvl_i >= WARN_LEVEL) begin
            req = ST_WARN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_SAFE;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
        end
    end

    // Release thresholds sit one metre below the request thresholds, so a
    // level wobbling by one metre around a threshold does not chatter.
    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        if (tick) begin
            if (state_q == ST_ALARM && lvl_i < WARN_LEVEL - 1) begin
                state_d = ST_SAFE;
            end else if (state_q == ST_ALARM && lvl_i < ALARM_LEVEL - 1) begin
                state_d = ST_WARN;
            end else if (state_q == ST_WARN && lvl_i < WARN_LEVEL - 1) begin
                state_d = ST_SAFE;
            end

            if (state_d != state_q) begin
                dwell_d = '0;
            end else if (req > state_q) begin
                if (dwell_q == DW'(DWELL_TICKS - 1)) begin
                    state_d = req;
                    dwell_d = '0;
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end else begin
                dwell_d = '0;
            end
        end
    end

    always_comb begin
        buzz_raw = 1'b0;
        case (state_q)
            ST_ALARM: buzz_raw = tone_q;
            ST_WARN:  buzz_raw = tone_q && (tick_cnt_q < CW'(CLK_HZ / 2));
            default:  buzz_raw = 1'b0;
        endcase
    end

`ifdef FLOOD_ALARM_MUTE_EN
    logic btn_q, muted_q;

    // A state change wins over a simultaneous button edge so that a new
    // condition is always announced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q   <= 1'b0;
            muted_q <= 1'b0;
        end else begin
            btn_q <= bus.btn_mute;
            if (state_d != state_q) begin
                muted_q <= 1'b0;
            end else if (bus.btn_mute && !btn_q) begin
                muted_q <= 1'b1;
            end
        end
    end

    assign buzz_en = ~muted_q;
`else
    assign buzz_en = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buzzer_q <= 1'b0;
        end else begin
            buzzer_q <= buzz_raw & buzz_en;
        end
    end

    assign bus.alarm_state = state_q;
    assign bus.buzzer      = buzzer_q;

    assign blank_tens = (lvl_q < 4'd10);
    assign ones       = blank_tens ? lvl_q : lvl_q - 4'd10;
    assign tens       = blank_tens ? 4'd0 : 4'd1;

    seg7_scan u_scan (
        .clk        (clk),
        .rst        (rst),
        .ones       (ones),
        .tens       (tens),
        .blank_tens (blank_tens),
        .seg        (bus.seg),
        .seg_sel    (bus.seg_sel)
    );

endmodule

// File: tb/tb_flood_alarm_ctrl.sv
// tb_flood_alarm_ctrl: directed scenarios with a cycle model of the alarm
// stage kept in terms of edge counts since reset release; every negedge the
// DUT outputs are compared to the model, and literal expectations pin the
// model at the interesting edges.
module tb_flood_alarm_ctrl;

    localparam int CLK_HZ      = 10;
    localparam int WARN_LEVEL  = 9;
    localparam int ALARM_LEVEL = 12;
    localparam int DWELL_TICKS = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmp_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    flood_alarm_ctrl_if ifc();

    flood_alarm_ctrl #(
        .CLK_HZ      (CLK_HZ),
        .WARN_LEVEL  (WARN_LEVEL),
        .ALARM_LEVEL (ALARM_LEVEL),
        .DWELL_TICKS (DWELL_TICKS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    logic [7:0] code_tab [0:9] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                   8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    // model state: edges since release, level seen by the design, alarm level
    int         m_cyc = 0;
    int         m_state = 0;
    int         m_streak = 0;
    int         m_lvl = 0;
    int         m_tone, m_cnt, m_req, m_nxt, m_old;
    logic       m_muted = 1'b0;
    logic       m_btn = 1'b0;
    logic [1:0] e_state = 2'b00;
    logic       e_buz = 1'b0;
    logic [7:0] e_seg = 8'h00;
    logic [7:0] e_sel = 8'hFF;

    always begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_cyc = 0; m_state = 0; m_streak = 0; m_lvl = 0;
            m_muted = 1'b0; m_btn = 1'b0;
            e_state = 2'b00; e_buz = 1'b0; e_seg = 8'h00; e_sel = 8'hFF;
        end else begin
            m_tone = m_cyc % 2;
            m_cnt  = m_cyc % CLK_HZ;
            if (m_tone == 0) begin
                e_sel = 8'hFE;
                e_seg = code_tab[m_lvl % 10];
            end else begin
                e_sel = 8'hFD;
                e_seg = (m_lvl >= 10) ? code_tab[m_lvl / 10] : 8'h00;
            end
            if (m_state == 2)      e_buz = (m_tone == 1);
            else if (m_state == 1) e_buz = (m_tone == 1) && (m_cnt < CLK_HZ / 2);
            else                   e_buz = 1'b0;
            if (m_muted) e_buz = 1'b0;

            m_old = m_state;
            if (m_cnt == CLK_HZ - 1) begin
                m_req = (m_lvl >= ALARM_LEVEL) ? 2 : (m_lvl >= WARN_LEVEL) ? 1 : 0;
                if (m_state == 2)
                    m_nxt = (m_lvl < WARN_LEVEL - 1) ? 0 : (m_lvl < ALARM_LEVEL - 1) ? 1 : 2;
                else if (m_state == 1)
                    m_nxt = (m_lvl < WARN_LEVEL - 1) ? 0 : 1;
                else
                    m_nxt = 0;
                if (m_nxt != m_state) begin
                    m_state  = m_nxt;
                    m_streak = 0;
                end else if (m_req > m_state) begin
                    m_streak = m_streak + 1;
                    if (m_streak >= DWELL_TICKS) begin
                        m_state  = m_req;
                        m_streak = 0;
                    end
                end else begin
                    m_streak = 0;
                end
            end
`ifdef FLOOD_ALARM_MUTE_EN
            if (m_state != m_old)            m_muted = 1'b0;
            else if (ifc.btn_mute && !m_btn) m_muted = 1'b1;
            m_btn = ifc.btn_mute;
`endif
            m_lvl   = int'(ifc.water_level);
            m_cyc   = m_cyc + 1;
            e_state = 2'(m_state);
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=0x%02h required=0x%02h edge=%0d t=%0t",
                     name, act, exp, m_cyc, $time);
        end
    endtask

    always begin
        @(negedge clk);
        if (cmp_en) begin
            check("state",   8'(ifc.alarm_state), 8'(e_state));
            check("buzzer",  8'(ifc.buzzer),      8'(e_buz));
            check("seg",     ifc.seg,             e_seg);
            check("seg_sel", ifc.seg_sel,         e_sel);
        end
    end

    task automatic goto_edge(input int e);
        int guard;
        guard = 0;
        while (m_cyc < e && guard < 2000) begin
            @(negedge clk);
            guard = guard + 1;
        end
        if (m_cyc != e) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL goto_edge actual=%0d required=%0d", m_cyc, e);
        end
    endtask

    task automatic do_reset(input logic [3:0] lvl);
        @(negedge clk);
        rst = 1'b1;
        ifc.water_level = lvl;
`ifdef FLOOD_ALARM_MUTE_EN
        ifc.btn_mute = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        ifc.water_level = 4'd0;
`ifdef FLOOD_ALARM_MUTE_EN
        ifc.btn_mute = 1'b0;
`endif
        #1 cmp_en = 1'b1;

        // reset and idle display at 5 m
        do_reset(4'd5);
        goto_edge(3);
        check("idle_seg_ones", ifc.seg, 8'h6D);
        check("idle_sel_ones", ifc.seg_sel, 8'hFE);
        goto_edge(4);
        check("idle_seg_tens", ifc.seg, 8'h00);
        check("idle_sel_tens", ifc.seg_sel, 8'hFD);
        check("idle_state", 8'(ifc.alarm_state), 8'h00);

        // escalation to WARN on the second tick at 9 m
        ifc.water_level = 4'd9;
        goto_edge(19);
        check("warn_before", 8'(ifc.alarm_state), 8'h00);
        goto_edge(20);
        check("warn_at_tick2", 8'(ifc.alarm_state), 8'h01);
        goto_edge(22);
        check("warn_beep_on", 8'(ifc.buzzer), 8'h01);
        goto_edge(28);
        check("warn_beep_quiet", 8'(ifc.buzzer), 8'h00);

        // one qualifying tick, then a non-qualifying one restarts the dwell
        do_reset(4'd9);
        goto_edge(10);
        ifc.water_level = 4'd8;
        goto_edge(20);
        check("dwell_broken", 8'(ifc.alarm_state), 8'h00);
        ifc.water_level = 4'd9;
        goto_edge(39);
        check("dwell_restart_wait", 8'(ifc.alarm_state), 8'h00);
        goto_edge(40);
        check("dwell_restart_warn", 8'(ifc.alarm_state), 8'h01);

        // direct SAFE -> ALARM at 15 m and two-digit display
        do_reset(4'd15);
        goto_edge(19);
        check("alarm_before", 8'(ifc.alarm_state), 8'h00);
        goto_edge(20);
        check("alarm_at_tick2", 8'(ifc.alarm_state), 8'h02);
        goto_edge(21);
        check("alarm_buz_e21", 8'(ifc.buzzer), 8'h00);
        goto_edge(22);
        check("alarm_buz_e22", 8'(ifc.buzzer), 8'h01);
        check("alarm_seg_tens", ifc.seg, 8'h06);
        check("alarm_sel_tens", ifc.seg_sel, 8'hFD);
        goto_edge(23);
        check("alarm_buz_e23", 8'(ifc.buzzer), 8'h00);
        check("alarm_seg_ones", ifc.seg, 8'h6D);
        check("alarm_sel_ones", ifc.seg_sel, 8'hFE);

        // hysteresis walk-down
        goto_edge(25);
        ifc.water_level = 4'd11;
        goto_edge(30);
        check("hyst_11_hold", 8'(ifc.alarm_state), 8'h02);
        ifc.water_level = 4'd10;
        goto_edge(40);
        check("hyst_10_warn", 8'(ifc.alarm_state), 8'h01);
        ifc.water_level = 4'd8;
        goto_edge(50);
        check("hyst_8_hold", 8'(ifc.alarm_state), 8'h01);
        ifc.water_level = 4'd7;
        goto_edge(60);
        check("hyst_7_safe", 8'(ifc.alarm_state), 8'h00);

        // reset in the middle of an escalation
        do_reset(4'd12);
        goto_edge(13);
        #2 rst = 1'b1;
        #1;
        check("midrst_state", 8'(ifc.alarm_state), 8'h00);
        check("midrst_buz", 8'(ifc.buzzer), 8'h00);
        check("midrst_seg", ifc.seg, 8'h00);
        check("midrst_sel", ifc.seg_sel, 8'hFF);
        @(negedge clk);
        rst = 1'b0;
        goto_edge(19);
        check("midrst_wait", 8'(ifc.alarm_state), 8'h00);
        goto_edge(20);
        check("midrst_alarm", 8'(ifc.alarm_state), 8'h02);

`ifdef FLOOD_ALARM_MUTE_EN
        // mute in ALARM, released by the drop to WARN
        do_reset(4'd15);
        goto_edge(22);
        ifc.btn_mute = 1'b1;
        for (int e = 24; e <= 29; e++) begin
            goto_edge(e);
            check("mute_buz", 8'(ifc.buzzer), 8'h00);
            check("mute_state", 8'(ifc.alarm_state), 8'h02);
        end
        ifc.water_level = 4'd10;
        goto_edge(40);
        check("unmute_warn", 8'(ifc.alarm_state), 8'h01);
        goto_edge(42);
        check("unmute_beep", 8'(ifc.buzzer), 8'h01);
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
